stream_bit_packer: RTL and testbench
====================================

// Module: stream_bit_packer
// PURPOSE
//  Parametrised sequential successor to our fixed bit-select concatenation logic.
//  Accepts variable-length bit fields (1..IN_W bits) over a valid/ready stream.
//  Concatenates them MSB-first into OUT_W-bit words on a valid/ready output stream.
//  On flush, emits a final partial word, zero-padded and flagged.
//  Sits between field-generating logic (headers, encoders) and word-wide buffers.
// PARAMETERS
//  IN_W   8   max field width in bits (>=1)
//  OUT_W  32  output word width in bits (OUT_W >= IN_W)
//  LEN_W  $clog2(IN_W+1)   width of in_len (derived; do not override)
//  CNT_W  $clog2(OUT_W+IN_W)  width of fill counter (derived; do not override)
// PORTS
//  clk        in   1      single clock; all state on rising edge
//  rst_n      in   1      asynchronous, active-low reset
//  in_valid   in   1      field present
//  in_ready   out  1      packer can accept a field this cycle
//  in_data    in   IN_W   field, right-aligned; bits above in_len ignored
//  in_len     in   LEN_W  field length; 0 = no-op, >IN_W clamped to IN_W
//  flush      in   1      request to drain, single-cycle pulse
//  out_valid  out  1      word available
//  out_ready  in   1      consumer accepts word
//  out_data   out  OUT_W  packed word; oldest bit at MSB
//  out_bits   out  CNT_W  valid bits in out_data (OUT_W, except on last word)
//  out_last   out  1      word is the final word of a flush
// BEHAVIOUR
//  - Clock/reset: one clock (clk); reset is asynchronous and active-low (rst_n).
//  - State:
//    - acc[OUT_W+IN_W-1:0]: right-aligned bit store.
//    - cnt: number of valid bits in acc.
//    - FSM: IDLE, FLUSH.
//  - Reset (async, immediate): acc=0, cnt=0, state=IDLE, out_valid=0, out_last=0,
//    out_bits=0, out_data=0. in_ready=1 once rst_n is high.
//  - Accept rule: in_fire = in_valid & in_ready.
//    - in_ready = (state==IDLE) & (cnt<OUT_W).
//    - On in_fire with L = min(in_len, IN_W):
//      acc <= (acc<<L) | (in_data & mask(L)); cnt <= cnt+L.
//  - Full word: out_valid=1 whenever cnt>=OUT_W.
//    - out_data = acc[cnt-1 -: OUT_W]; out_bits=OUT_W; out_last=0.
//    - On out_fire (out_valid & out_ready): cnt <= cnt-OUT_W; surplus low bits retained.
//  - in_fire and full-word out_fire are mutually exclusive by construction.
//    cnt never exceeds OUT_W+IN_W-1.
//  - Latency: a field completing a word gives out_valid on the next cycle.
//  - Backpressure: out_data, out_bits and out_last stay stable while out_valid & !out_ready.
//  - Flush:
//    - flush is sampled only in IDLE; IDLE -> FLUSH. flush in FLUSH is ignored.
//    - In FLUSH, in_ready=0. Full words drain first, per the normal rule.
//    - When 0<cnt<OUT_W, out_valid=1 with the partial word:
//      out_data = acc[cnt-1:0] left-aligned, zero-padded; out_bits=cnt; out_last=1.
//      Its out_fire sets cnt<=0, acc<=0, FSM -> IDLE.
//    - If cnt==0 on entering FLUSH, or after the drain, FSM -> IDLE on the next cycle
//      with no output word.
//  - flush coincident with in_fire: the field is packed first, then flushed.
//  - Reset mid-operation discards all held bits; no partial word is emitted.
// STRUCTURE
//  - Package stream_bit_packer_pkg holds:
//    - state enum {IDLE, FLUSH};
//    - LEN_W/CNT_W derivation functions;
//    - mask function mask(L) = (1<<L)-1, width IN_W.
//  - One sub-module: bit_field_mask (combinational length->mask, with clamp).
//  - Top level holds acc/cnt registers, FSM and output alignment shifter.
// TESTING  (IN_W=8, OUT_W=16 unless noted)
//  1. Reset:
//     rst_n low -> out_valid=0, out_last=0, cnt=0; after release, in_ready=1.
//  2. Fields 0xA,0xB,0xC,0xD with len=4 each:
//     -> one word 0xABCD, out_bits=16, out_last=0; in_ready returns to 1 after out_fire.
//  3. Six fields 3'b101 with len=3 (18 bits):
//     -> word 0xB6DB, cnt=2 remain.
//     Then flush -> word 0x4000, out_bits=2, out_last=1; FSM back to IDLE.
//  4. Backpressure: complete a word, hold out_ready=0 for 10 cycles:
//     -> out_data stable, in_ready=0; word emitted once on release.
//  5. Edge lengths:
//     - in_len=0 -> cnt unchanged.
//     - in_data=0xFF with in_len=15 -> clamped to 8 bits.
//     - flush with cnt=0 -> no out_valid; IDLE after 1 cycle.
//  6. Drop rst_n while the flushed partial word is waiting on out_ready=0:
//     -> out_valid=0 immediately, cnt=0; no word emitted after reset release.

Source files
------------

// File: rtl/stream_bit_packer_pkg.sv
// Shared types and helpers for the stream bit packer.
//   state_t     : packer FSM states (IDLE accepts fields, FLUSH drains)
//   calc_len_w  : width of the field-length port for a given max field width
//   calc_cnt_w  : width of the fill counter for given field/word widths
//   mask        : (1<<l)-1, returned MAX_IN_W wide; callers truncate to IN_W
package stream_bit_packer_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } state_t;

  localparam int MAX_IN_W = 64;

  function automatic int calc_len_w(input int in_w);
    return $clog2(in_w + 1);
  endfunction

  function automatic int calc_cnt_w(input int in_w, input int out_w);
    return $clog2(out_w + in_w);
  endfunction

  function automatic logic [MAX_IN_W-1:0] mask(input int l);
    logic [MAX_IN_W-1:0] m;
    m = '0;
    for (int i = 0; i < MAX_IN_W; i++) begin
      if (i < l) m[i] = 1'b1;
    end
    return m;
  endfunction

endpackage

// File: rtl/bit_field_mask.sv
// Length clamp and field mask generation.
//   i_len  : requested field length (any value representable in LEN_W)
//   o_len  : length clamped to IN_W
//   o_mask : low o_len bits set, IN_W wide
module bit_field_mask
  import stream_bit_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int LEN_W = calc_len_w(IN_W)
) (
  input  logic [LEN_W-1:0] i_len,
  output logic [LEN_W-1:0] o_len,
  output logic [IN_W-1:0]  o_mask
);

  localparam logic [LEN_W-1:0] MAX_LEN = LEN_W'(IN_W);

  logic [LEN_W-1:0] w_len;

  assign w_len  = (i_len > MAX_LEN) ? MAX_LEN : i_len;
  assign o_len  = w_len;
  assign o_mask = IN_W'(mask(int'(w_len)));

endmodule

// File: rtl/stream_bit_packer.sv
// Packs variable-length bit fields MSB-first into OUT_W-bit words.
//   clk, rst_n      : clock, asynchronous active-low reset
//   i_in_valid      : field present        o_in_ready : field accepted this cycle
//   i_in_data       : right-aligned field  i_in_len   : field length (0 = no-op)
//   i_flush         : drain request pulse (honoured in IDLE only)
//   o_out_valid     : word available       i_out_ready: consumer accepts word
//   o_out_data      : packed word, oldest bit at MSB
//   o_out_bits      : valid bits in o_out_data
//   o_out_last      : final (partial) word of a flush
module stream_bit_packer
  import stream_bit_packer_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 32,
  parameter int LEN_W = calc_len_w(IN_W),
  parameter int CNT_W = calc_cnt_w(IN_W, OUT_W)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_in_valid,
  output logic             o_in_ready,
  input  logic [IN_W-1:0]  i_in_data,
  input  logic [LEN_W-1:0] i_in_len,
  input  logic             i_flush,
  output logic             o_out_valid,
  input  logic             i_out_ready,
  output logic [OUT_W-1:0] o_out_data,
  output logic [CNT_W-1:0] o_out_bits,
  output logic             o_out_last
);

  localparam int               ACC_W   = OUT_W + IN_W;
  localparam logic [CNT_W-1:0] OUT_W_C = CNT_W'(OUT_W);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [ACC_W-1:0] r_acc;
  logic [CNT_W-1:0] r_cnt;

  logic [LEN_W-1:0] w_len;
  logic [IN_W-1:0]  w_mask;
  logic             w_full;
  logic             w_partial;
  logic             w_in_fire;
  logic             w_out_fire;

  bit_field_mask #(
    .IN_W  (IN_W),
    .LEN_W (LEN_W)
  ) u_mask (
    .i_len  (i_in_len),
    .o_len  (w_len),
    .o_mask (w_mask)
  );

  assign w_full      = (r_cnt >= OUT_W_C);
  assign w_partial   = (r_state == FLUSH) && !w_full && (r_cnt != '0);
  assign o_in_ready  = (r_state == IDLE) && !w_full;
  assign o_out_valid = w_full || w_partial;
  assign w_in_fire   = i_in_valid && o_in_ready;
  assign w_out_fire  = o_out_valid && i_out_ready;

  // Bits above r_cnt in r_acc are stale; both alignments shift them out of
  // the OUT_W window, so no clearing is needed after a full-word drain.
  always_comb begin
    o_out_data = '0;
    o_out_bits = '0;
    o_out_last = 1'b0;
    if (w_full) begin
      o_out_data = OUT_W'(r_acc >> (r_cnt - OUT_W_C));
      o_out_bits = OUT_W_C;
    end else if (w_partial) begin
      o_out_data = OUT_W'(r_acc << (OUT_W_C - r_cnt));
      o_out_bits = r_cnt;
      o_out_last = 1'b1;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (i_flush) w_state_nxt = FLUSH;
      FLUSH: begin
        if (w_partial && i_out_ready) w_state_nxt = IDLE;
        else if (r_cnt == '0)         w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= IDLE;
    else        r_state <= w_state_nxt;
  end

  // in_fire needs cnt<OUT_W and out_fire needs cnt>=OUT_W or FLUSH, so the
  // two never coincide and a single priority chain covers the datapath.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= '0;
    end else if (w_in_fire) begin
      r_acc <= (r_acc << w_len) | {{OUT_W{1'b0}}, (i_in_data & w_mask)};
      r_cnt <= r_cnt + CNT_W'(w_len);
    end else if (w_out_fire) begin
      if (w_full) begin
        r_cnt <= r_cnt - OUT_W_C;
      end else begin
        r_cnt <= '0;
        r_acc <= '0;
      end
    end
  end

endmodule

// File: tb/tb_stream_bit_packer.sv
module tb_stream_bit_packer;

  localparam int IN_W  = 8;
  localparam int OUT_W = 16;
  localparam int LEN_W = 4;
  localparam int CNT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [IN_W-1:0]  in_data;
  logic [LEN_W-1:0] in_len;
  logic             flush;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_data;
  logic [CNT_W-1:0] out_bits;
  logic             out_last;

  typedef struct {
    logic [OUT_W-1:0] data;
    logic [CNT_W-1:0] bits;
    logic             last;
  } exp_t;

  exp_t sb[$];
  bit   mdl[$];
  int   n_vec = 0;
  int   n_err = 0;

  stream_bit_packer #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_in_valid  (in_valid),
    .o_in_ready  (in_ready),
    .i_in_data   (in_data),
    .i_in_len    (in_len),
    .i_flush     (flush),
    .o_out_valid (out_valid),
    .i_out_ready (out_ready),
    .o_out_data  (out_data),
    .o_out_bits  (out_bits),
    .o_out_last  (out_last)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: every word that fires is compared against the oldest expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (rst_n && out_valid && out_ready) begin
      n_vec++;
      if (sb.size() == 0) begin
        n_err++;
        $display("FAIL unexpected_word: got data=%h bits=%0d last=%b, expected no word",
                 out_data, out_bits, out_last);
      end else begin
        e = sb.pop_front();
        if (out_data !== e.data || out_bits !== e.bits || out_last !== e.last) begin
          n_err++;
          $display("FAIL word: got data=%h bits=%0d last=%b, expected data=%h bits=%0d last=%b",
                   out_data, out_bits, out_last, e.data, e.bits, e.last);
        end
      end
    end
  end

  task automatic model_push(input logic [7:0] d, input int len);
    int l;
    exp_t e;
    l = (len > IN_W) ? IN_W : len;
    for (int i = l - 1; i >= 0; i--) mdl.push_back(d[i]);
    while (mdl.size() >= OUT_W) begin
      e.data = '0;
      for (int i = OUT_W - 1; i >= 0; i--) e.data[i] = mdl.pop_front();
      e.bits = CNT_W'(OUT_W);
      e.last = 1'b0;
      sb.push_back(e);
    end
  endtask

  task automatic model_flush();
    exp_t e;
    int   n;
    n = mdl.size();
    if (n > 0) begin
      e.data = '0;
      for (int i = 0; i < n; i++) e.data[OUT_W-1-i] = mdl.pop_front();
      e.bits = CNT_W'(n);
      e.last = 1'b1;
      sb.push_back(e);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the field is taken.
  task automatic send(input logic [7:0] d, input logic [3:0] l, input bit fl);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (in_ready) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL send_timeout: in_ready=%b after 100 cycles, expected 1", in_ready);
    end
    flush = fl;
    model_push(d, int'(l));
    if (fl) model_flush();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    flush    = 1'b0;
    in_data  = '0;
    in_len   = '0;
  endtask

  task automatic pulse_flush();
    flush = 1'b1;
    model_flush();
    @(posedge clk);
    #1;
    flush = 1'b0;
  endtask

  task automatic wait_drain(input string name);
    bit ok;
    ok = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (sb.size() == 0 && !out_valid) begin
        ok = 1'b1;
        break;
      end
    end
    n_vec++;
    if (!ok) begin
      n_err++;
      $display("FAIL %s_drain: %0d words outstanding, out_valid=%b, expected 0 and 0",
               name, sb.size(), out_valid);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string name);
    @(negedge clk);
    n_vec++;
    if (in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL %s_idle: in_ready=%b, expected 1", name, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_data = '0; in_len = '0;
    flush = 1'b0; out_ready = 1'b0;
    #12;
    n_vec += 4;
    if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b, expected 0", out_valid); end
    if (out_last  !== 1'b0) begin n_err++; $display("FAIL reset_last: got %b, expected 0", out_last); end
    if (out_bits  !== '0)   begin n_err++; $display("FAIL reset_bits: got %0d, expected 0", out_bits); end
    if (out_data  !== '0)   begin n_err++; $display("FAIL reset_data: got %h, expected 0", out_data); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check_idle("reset");
  endtask

  task automatic test_nibbles();
    out_ready = 1'b1;
    send(8'h0A, 4'd4, 1'b0);
    send(8'h0B, 4'd4, 1'b0);
    send(8'h0C, 4'd4, 1'b0);
    send(8'h0D, 4'd4, 1'b0);
    wait_drain("nibbles");
    check_idle("nibbles");
  endtask

  task automatic test_three_bit();
    out_ready = 1'b1;
    for (int i = 0; i < 6; i++) send(8'b101, 4'd3, 1'b0);
    pulse_flush();
    wait_drain("three_bit");
    check_idle("three_bit");
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    send(8'h01, 4'd4, 1'b0);
    send(8'h02, 4'd4, 1'b0);
    send(8'h03, 4'd4, 1'b0);
    send(8'h04, 4'd4, 1'b0);
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b1 || out_data !== 16'h1234 || in_ready !== 1'b0) begin
        n_err++;
        $display("FAIL backpressure_hold[%0d]: valid=%b data=%h in_ready=%b, expected 1 1234 0",
                 c, out_valid, out_data, in_ready);
      end
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    wait_drain("backpressure");
    check_idle("backpressure");
  endtask

  task automatic test_edges();
    out_ready = 1'b1;
    send(8'hFF, 4'd15, 1'b0);
    send(8'hFF, 4'd0,  1'b0);
    send(8'h00, 4'd8,  1'b0);
    wait_drain("edges");
    flush = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b0) begin
      n_err++;
      $display("FAIL empty_flush_state: valid=%b in_ready=%b, expected 0 0", out_valid, in_ready);
    end
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      n_err++;
      $display("FAIL empty_flush_idle: valid=%b in_ready=%b, expected 0 1", out_valid, in_ready);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic test_back_to_back();
    logic [7:0] d;
    logic [3:0] l;
    out_ready = 1'b1;
    for (int i = 0; i < 14; i++) begin
      d = 8'($urandom_range(0, 255));
      l = 4'($urandom_range(0, 10));
      send(d, l, i == 13);
    end
    wait_drain("back_to_back");
    check_idle("back_to_back");
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0;
    send(8'h09, 4'd4, 1'b0);
    send(8'h06, 4'd4, 1'b0);
    send(8'h03, 4'd4, 1'b0);
    pulse_flush();
    @(negedge clk);
    n_vec++;
    if (out_valid !== 1'b1 || out_last !== 1'b1 || out_bits !== 5'd12 || out_data !== 16'h9630) begin
      n_err++;
      $display("FAIL mid_partial: valid=%b last=%b bits=%0d data=%h, expected 1 1 12 9630",
               out_valid, out_last, out_bits, out_data);
    end
    #1;
    rst_n = 1'b0;
    #1;
    n_vec++;
    if (out_valid !== 1'b0 || out_bits !== '0 || out_last !== 1'b0) begin
      n_err++;
      $display("FAIL mid_reset: valid=%b bits=%0d last=%b, expected 0 0 0",
               out_valid, out_bits, out_last);
    end
    sb.delete();
    mdl.delete();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      n_vec++;
      if (out_valid !== 1'b0) begin
        n_err++;
        $display("FAIL mid_after_reset[%0d]: valid=%b, expected 0", c, out_valid);
      end
    end
    check_idle("reset_mid");
  endtask

  initial begin
    test_reset();
    test_nibbles();
    test_three_bit();
    test_backpressure();
    test_edges();
    test_back_to_back();
    test_reset_mid();
    n_vec++;
    if (sb.size() != 0) begin
      n_err++;
      $display("FAIL leftover_words: %0d outstanding, expected 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
